// File: rtl/rgb_to_hsv_if.sv
// rgb_to_hsv_if: start/valid handshake bundle for the RGB to HSV converter
// master drives start and the three duty cycles; slave returns busy, valid and the HSV result
interface rgb_to_hsv_if #(parameter int DATA_W = 8);
  logic              start;
  logic [DATA_W-1:0] red_dutycycle;
  logic [DATA_W-1:0] green_dutycycle;
  logic [DATA_W-1:0] blue_dutycycle;
  logic              busy;
  logic              valid;
  logic [8:0]        hue;
  logic [DATA_W-1:0] saturation;
  logic [DATA_W-1:0] value;
  modport master (output start, red_dutycycle, green_dutycycle, blue_dutycycle,
                  input busy, valid, hue, saturation, value);
  modport slave  (input start, red_dutycycle, green_dutycycle, blue_dutycycle,
                  output busy, valid, hue, saturation, value);
endinterface

// File: rtl/rgb_to_hsv.sv
// rgb_to_hsv: integer RGB to HSV converter sharing one restoring divider for saturation then hue
// ports: clock_i rising-edge clock, reset_i async active-low reset, bus slave handshake/result bundle
module rgb_to_hsv #(
  parameter int DATA_W = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  rgb_to_hsv_if.slave  bus
);
  localparam int QW = 2 * DATA_W;
  localparam int CW = $clog2(QW);
  typedef enum logic [2:0] {IDLE, LOAD, DIV_S, DIV_H, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [DATA_W-1:0] max_q, max_d, delta_q, delta_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [DATA_W-1:0] sat_q, sat_d, sat_o_q, sat_o_d, val_q, val_d;
  logic [QW-1:0]     num_q, num_d, quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        dom_q, dom_d;
  logic              neg_q, neg_d;
  logic [8:0]        hue_q, hue_d;
  logic [DATA_W-1:0] mx, mn;
  logic [1:0]        dom;
  logic signed [DATA_W+1:0] diff;
  logic [DATA_W:0]   mag, sh, sub;
  logic [QW-1:0]     quo_n;
  logic              ge, last;
  logic [9:0]        off;
  logic signed [10:0] h_raw, h_wrap;
  logic [8:0]        hue_fin;
  always_comb begin
    mx = r_q >= g_q ? (r_q >= b_q ? r_q : b_q) : (g_q >= b_q ? g_q : b_q);
    mn = r_q <= g_q ? (r_q <= b_q ? r_q : b_q) : (g_q <= b_q ? g_q : b_q);
    // ties resolve R, then G, then B
    dom = (r_q >= g_q && r_q >= b_q) ? 2'd0 : (g_q >= b_q ? 2'd1 : 2'd2);
    diff = dom == 2'd0 ? $signed({2'b0, g_q}) - $signed({2'b0, b_q}) :
           dom == 2'd1 ? $signed({2'b0, b_q}) - $signed({2'b0, r_q}) :
                         $signed({2'b0, r_q}) - $signed({2'b0, g_q});
    mag = (DATA_W+1)'(diff[DATA_W+1] ? -diff : diff);
    // one restoring step: remainder stays below the divisor, so DATA_W+1 bits hold the shifted trial
    sh = {rem_q, quo_q[QW-1]};
    ge = sh >= {1'b0, dvs_q};
    sub = sh - {1'b0, dvs_q};
    quo_n = {quo_q[QW-2:0], ge};
    last = cnt_q == CW'(QW - 1);
    off = dom_q == 2'd0 ? 10'd0 : dom_q == 2'd1 ? 10'd120 : 10'd240;
    h_raw = neg_q ? $signed({1'b0, off}) - $signed({1'b0, quo_n[9:0]})
                  : $signed({1'b0, off}) + $signed({1'b0, quo_n[9:0]});
    h_wrap = h_raw < 0 ? h_raw + 11'sd360 : h_raw;
    hue_fin = (delta_q == '0 || h_wrap == 11'sd360) ? 9'd0 : h_wrap[8:0];
  end
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    max_d = max_q;
    delta_d = delta_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    num_d = num_q;
    dom_d = dom_q;
    neg_d = neg_q;
    sat_d = sat_q;
    sat_o_d = sat_o_q;
    val_d = val_q;
    hue_d = hue_q;
    cnt_d = '0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        r_d = bus.red_dutycycle;
        g_d = bus.green_dutycycle;
        b_d = bus.blue_dutycycle;
        state_d = LOAD;
      end
      LOAD: begin
        max_d = mx;
        delta_d = mx - mn;
        dom_d = dom;
        neg_d = diff[DATA_W+1];
        num_d = QW'(mag) * QW'(60);
        quo_d = QW'(mx - mn) * QW'((1 << DATA_W) - 1);
        dvs_d = mx;
        rem_d = '0;
        state_d = DIV_S;
      end
      DIV_S: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = sub[DATA_W-1:0];
        rem_d = ge ? sub[DATA_W-1:0] : sh[DATA_W-1:0];
        quo_d = quo_n;
        if (last) begin
          sat_d = quo_n[DATA_W-1:0];
          quo_d = num_q;
          dvs_d = delta_q;
          rem_d = '0;
          state_d = DIV_H;
        end
      end
      DIV_H: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = ge ? sub[DATA_W-1:0] : sh[DATA_W-1:0];
        quo_d = quo_n;
        if (last) begin
          hue_d = hue_fin;
          sat_o_d = max_q == '0 ? '0 : sat_q;
          val_d = max_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      max_q <= '0;
      delta_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      num_q <= '0;
      dom_q <= '0;
      neg_q <= 1'b0;
      sat_q <= '0;
      sat_o_q <= '0;
      val_q <= '0;
      hue_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      max_q <= max_d;
      delta_q <= delta_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      num_q <= num_d;
      dom_q <= dom_d;
      neg_q <= neg_d;
      sat_q <= sat_d;
      sat_o_q <= sat_o_d;
      val_q <= val_d;
      hue_q <= hue_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.valid = state_q == DONE;
  assign bus.hue = hue_q;
  assign bus.saturation = sat_o_q;
  assign bus.value = val_q;
endmodule
